// File: rtl/vmx_requant_if.sv
// Requantizer bus: job control, result-buffer read port and
// input-buffer write port.
interface vmx_requant_if #(
    parameter int LANES  = 4,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 8
);
    logic                     start;
    logic [ADDR_W-1:0]        rbase_addr;
    logic [ADDR_W-1:0]        wbase_addr;
    logic [ADDR_W-1:0]        count;
    logic [4:0]               shift;
    logic                     relu_en;
    logic [LANES*ACC_W-1:0]   bias;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [LANES*ACC_W-1:0]   rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [LANES*OUT_W-1:0]   wr_data;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        sat_cnt;

    modport slave (
        input  start, rbase_addr, wbase_addr, count,
        input  shift, relu_en, bias, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output busy, done, sat_cnt
    );

    modport master (
        output start, rbase_addr, wbase_addr, count,
        output shift, relu_en, bias, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  busy, done, sat_cnt
    );
endinterface

// File: rtl/vmx_requant.sv
// Requantizer: bias add, rounding shift, ReLU and 16-bit
// saturation from result buffer to input buffer.
module vmx_requant #(
    parameter int LANES  = 4,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    vmx_requant_if.slave  bus
);
    localparam int SW = ACC_W + 2;
    localparam int NW = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]      rem;
    logic [ADDR_W-1:0]      wptr;
    logic [4:0]             shift_q;
    logic                   relu_q;
    logic [LANES*ACC_W-1:0] bias_q;
    logic                   rv;
    logic                   s1_v;
    logic [LANES-1:0][SW-1:0] s1_q;
    logic [LANES-1:0][SW-1:0] s1_d;
    logic [LANES-1:0][SW-1:0] sh_v;
    logic [SW-1:0]          rnd;
    logic [SW-1:0]          a_ext;
    logic [SW-1:0]          b_ext;
    logic [LANES*OUT_W-1:0] q_d;
    logic [NW-1:0]          nsat;
    logic [NW-1:0]          sat_sum;
    logic [ADDR_W-1:0]      sat_nx;
    logic                   accept;

    assign accept = (state == IDLE) && bus.start;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) state_nx = FIN;
                    else                 state_nx = READ;
                end
            end
            READ: begin
                if (rem == '0) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!rv && !s1_v) state_nx = FIN;
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage 1: 34-bit sum leaves room for bias plus the rounding half-LSB.
    always_comb begin
        rnd   = (SW'(1) << shift_q) >> 1;
        s1_d  = '0;
        a_ext = '0;
        b_ext = '0;
        for (int k = 0; k < LANES; k++) begin
            a_ext = {{2{bus.rd_data[k*ACC_W+ACC_W-1]}},
                     bus.rd_data[k*ACC_W +: ACC_W]};
            b_ext = {{2{bias_q[k*ACC_W+ACC_W-1]}},
                     bias_q[k*ACC_W +: ACC_W]};
            s1_d[k] = a_ext + b_ext + rnd;
        end
    end

    // Stage 2: ReLU before the range check so zeroing never counts as a clamp.
    always_comb begin
        sh_v = '0;
        q_d  = '0;
        nsat = '0;
        for (int k = 0; k < LANES; k++) begin
            sh_v[k] = $signed(s1_q[k]) >>> shift_q;
            if (relu_q && sh_v[k][SW-1]) sh_v[k] = '0;
            if ((sh_v[k][SW-1:OUT_W-1] == '0) ||
                (sh_v[k][SW-1:OUT_W-1] == '1)) begin
                q_d[k*OUT_W +: OUT_W] = sh_v[k][OUT_W-1:0];
            end else begin
                nsat = nsat + NW'(1);
                if (sh_v[k][SW-1])
                    q_d[k*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
                else
                    q_d[k*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
        sat_sum = {1'b0, bus.sat_cnt} + nsat;
        sat_nx  = sat_sum[NW-1] ? '1 : sat_sum[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            rem         <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
        end else begin
            state    <= state_nx;
            bus.busy <= (state_nx != IDLE);
            bus.done <= (state_nx == FIN);
            if (accept) begin
                shift_q <= bus.shift;
                relu_q  <= bus.relu_en;
                bias_q  <= bus.bias;
                rem     <= bus.count - ADDR_W'(1);
                if (bus.count != '0) begin
                    bus.rd_en   <= 1'b1;
                    bus.rd_addr <= bus.rbase_addr;
                end
            end else if (state == READ) begin
                if (rem == '0) begin
                    bus.rd_en   <= 1'b0;
                    bus.rd_addr <= '0;
                end else begin
                    bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                    rem         <= rem - ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv          <= 1'b0;
            s1_v        <= 1'b0;
            s1_q        <= '0;
            wptr        <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.sat_cnt <= '0;
        end else begin
            rv        <= bus.rd_en;
            s1_v      <= rv;
            if (rv) s1_q <= s1_d;
            bus.wr_en   <= s1_v;
            bus.wr_addr <= s1_v ? wptr : '0;
            bus.wr_data <= s1_v ? q_d : '0;
            if (accept) begin
                wptr        <= bus.wbase_addr;
                bus.sat_cnt <= '0;
            end else if (s1_v) begin
                wptr        <= wptr + ADDR_W'(1);
                bus.sat_cnt <= sat_nx;
            end
        end
    end
endmodule

// File: tb/tb_vmx_requant.sv
// Bench for vmx_requant: directed jobs plus random jobs against
// an integer reference model of the requantization rules.
module tb_vmx_requant;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vmx_requant_if bus ();

    vmx_requant dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [127:0] mem [256];

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_lane(input int acc, input int b,
                                             input int sh, input bit relu,
                                             output bit sat);
        longint v;
        v = longint'(acc) + longint'(b);
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        sat = 1'b0;
        if (v > 32767) begin
            v = 32767;
            sat = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            sat = 1'b1;
        end
        return v[15:0];
    endfunction

    function automatic logic [63:0] ref_word(input logic [127:0] w,
                                             input logic [127:0] b,
                                             input int sh, input bit relu,
                                             output int ns);
        logic [63:0] r;
        bit s;
        ns = 0;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k*16 +: 16] = ref_lane(int'(w[k*32 +: 32]),
                                     int'(b[k*32 +: 32]), sh, relu, s);
            ns += int'(s);
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_acc();
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: return 32'($urandom_range(0, 200000)) - 32'd100000;
            default: return 32'($urandom_range(0, 60000)) - 32'd30000;
        endcase
    endfunction

    function automatic logic [127:0] rnd_word();
        return {rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc()};
    endfunction

    task automatic scramble();
        bus.rbase_addr = 8'($urandom);
        bus.wbase_addr = 8'($urandom);
        bus.count      = 8'($urandom);
        bus.shift      = 5'($urandom);
        bus.relu_en    = 1'($urandom);
        bus.bias       = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_job(input string tag,
                           input logic [7:0] rb, input logic [7:0] wb,
                           input logic [7:0] cn, input logic [4:0] sh,
                           input logic rl, input logic [127:0] bi,
                           input bit mid, output logic [63:0] last_wd);
        int nr, nw, bcnt, dn, exp_sat, ns, exp_done;
        logic prv;
        logic [7:0] pa, ea;
        logic [63:0] ew;
        exp_done = (cn == 0) ? 1 : int'(cn) + 4;
        exp_sat = 0;
        nr = 0; nw = 0; bcnt = 0; dn = 0;
        prv = 1'b0; pa = '0; last_wd = '0;
        bus.start = 1'b1;
        bus.rbase_addr = rb;
        bus.wbase_addr = wb;
        bus.count = cn;
        bus.shift = sh;
        bus.relu_en = rl;
        bus.bias = bi;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        for (int cyc = 1; cyc <= int'(cn) + 12; cyc++) begin
            bus.rd_data = prv ? mem[pa]
                              : {$urandom, $urandom, $urandom, $urandom};
            if (mid && cyc == 2) begin
                bus.start = 1'b1;
                bus.count = 8'd3;
                bus.rbase_addr = 8'd10;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dn++;
                chk({tag, " done_cycle"}, 128'(cyc), 128'(exp_done));
            end
            if (bus.rd_en) begin
                ea = rb + 8'(nr);
                chk({tag, " rd_addr"}, bus.rd_addr, ea);
                chk({tag, " rd_cycle"}, 128'(cyc), 128'(nr + 1));
                nr++;
            end else begin
                chk({tag, " rd_addr_idle"}, bus.rd_addr, 0);
            end
            if (bus.wr_en) begin
                ea = rb + 8'(nw);
                ew = ref_word(mem[ea], bi, int'(sh), rl, ns);
                exp_sat += ns;
                ea = wb + 8'(nw);
                chk({tag, " wr_addr"}, bus.wr_addr, ea);
                chk({tag, " wr_data"}, bus.wr_data, ew);
                chk({tag, " wr_cycle"}, 128'(cyc), 128'(nw + 4));
                last_wd = bus.wr_data;
                nw++;
            end else begin
                chk({tag, " wr_data_idle"}, bus.wr_data, 0);
            end
            prv = bus.rd_en;
            pa = bus.rd_addr;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk({tag, " reads"}, 128'(nr), 128'(cn));
        chk({tag, " writes"}, 128'(nw), 128'(cn));
        chk({tag, " busy_cycles"}, 128'(bcnt), 128'(exp_done));
        chk({tag, " done_pulses"}, 128'(dn), 128'(1));
        chk({tag, " sat_cnt"}, bus.sat_cnt,
            128'((exp_sat > 255) ? 255 : exp_sat));
    endtask

    initial begin
        logic [63:0] wd;
        logic [127:0] bi;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.rbase_addr = '0;
        bus.wbase_addr = '0;
        bus.count = '0;
        bus.shift = '0;
        bus.relu_en = 1'b0;
        bus.bias = '0;
        bus.rd_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = rnd_word();
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_en", bus.rd_en, 0);
        chk("reset rd_addr", bus.rd_addr, 0);
        chk("reset wr_en", bus.wr_en, 0);
        chk("reset wr_addr", bus.wr_addr, 0);
        chk("reset wr_data", bus.wr_data, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset sat_cnt", bus.sat_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem[8'd20] = {32'h0, 32'h7FFF, 32'hFFFF_FFF9, 32'h5};
        run_job("basic", 8'd20, 8'd40, 8'd1, 5'd0, 1'b0, '0, 1'b0, wd);
        chk("basic lanes", wd, {16'h0, 16'h7FFF, 16'hFFF9, 16'h0005});

        mem[8'd30] = {32'h0, 32'h0, 32'hFFFF_FFD8, 32'h18};
        bi = {32'h0, 32'h0, 32'h0, 32'h8};
        run_job("round", 8'd30, 8'd50, 8'd1, 5'd4, 1'b0, bi, 1'b0, wd);
        chk("round lanes", wd, {16'h0, 16'h0, 16'hFFFE, 16'h0002});

        mem[8'd60] = {32'h9C40, 32'hFFFF_FFFB, 32'hFFFE_7960, 32'h186A0};
        run_job("sat", 8'd60, 8'd70, 8'd1, 5'd0, 1'b0, '0, 1'b0, wd);
        chk("sat lanes", wd, {16'h7FFF, 16'hFFFB, 16'h8000, 16'h7FFF});
        chk("sat count3", bus.sat_cnt, 3);
        run_job("relu", 8'd60, 8'd71, 8'd1, 5'd0, 1'b1, '0, 1'b0, wd);
        chk("relu lanes", wd, {16'h7FFF, 16'h0, 16'h0, 16'h7FFF});
        chk("relu count2", bus.sat_cnt, 2);

        bi = {$urandom, $urandom, $urandom, $urandom};
        run_job("wrap", 8'd254, 8'd253, 8'd4, 5'd7, 1'b0, bi, 1'b1, wd);

        run_job("empty", 8'd5, 8'd6, 8'd0, 5'd0, 1'b0, '0, 1'b0, wd);

        for (int j = 0; j < 6; j++) begin
            bi = {rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc()};
            run_job($sformatf("rand%0d", j), 8'($urandom), 8'($urandom),
                    8'($urandom_range(1, 20)), 5'($urandom),
                    1'($urandom), bi, 1'b0, wd);
        end

        bus.start = 1'b1;
        bus.rbase_addr = 8'd0;
        bus.wbase_addr = 8'd100;
        bus.count = 8'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_mid reading", bus.rd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid rd_en", bus.rd_en, 0);
        chk("rst_mid rd_addr", bus.rd_addr, 0);
        chk("rst_mid wr_en", bus.wr_en, 0);
        chk("rst_mid wr_data", bus.wr_data, 0);
        chk("rst_mid busy", bus.busy, 0);
        chk("rst_mid done", bus.done, 0);
        chk("rst_mid sat_cnt", bus.sat_cnt, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("post_rst idle",
                {bus.busy, bus.rd_en, bus.wr_en, bus.done}, 0);
        end
        bi = {rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc()};
        run_job("post_rst", 8'd0, 8'd100, 8'd5, 5'd3, 1'b1, bi, 1'b0, wd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
